// File: rtl/tb_run_controller_if.sv
// tb_run_controller_if: host and scoreboard signals of the run controller.
// The master side starts runs and supplies counters; the slave side sequences the run.
interface tb_run_controller_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic             i_abort;
   logic [WIDTH-1:0] i_num_samples;
   logic [WIDTH-1:0] i_err_limit;
   logic [WIDTH-1:0] i_data_ctr;
   logic [WIDTH-1:0] i_event_ctr;
   logic             o_tb_reset;
   logic             o_tb_enable;
   logic             o_tb_freeze;
   logic             o_busy;
   logic             o_done;
   logic [1:0]       o_status;
   logic [WIDTH-1:0] o_run_cycles;

   modport master (
      output i_start, i_abort, i_num_samples, i_err_limit, i_data_ctr, i_event_ctr,
      input  o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done, o_status, o_run_cycles
   );

   modport slave (
      input  i_start, i_abort, i_num_samples, i_err_limit, i_data_ctr, i_event_ctr,
      output o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done, o_status, o_run_cycles
   );
endinterface

// File: rtl/tb_run_controller.sv
// tb_run_controller: sequences clear, pipeline fill, counted run and stop for one test run,
// ending the run on abort, error limit, sample target or data stall.
module tb_run_controller #(
   parameter int WIDTH      = 32,
   parameter int RST_CYCLES = 4,
   parameter int PIPE_LAT   = 8,
   parameter int TIMEOUT    = 1024
) (
   input logic                clk,
   input logic                reset,
   tb_run_controller_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FLUSH, S_RUN, S_STOP, S_DONE} state_t;

   localparam logic [1:0] ST_PASS  = 2'd0;
   localparam logic [1:0] ST_FAIL  = 2'd1;
   localparam logic [1:0] ST_ABORT = 2'd2;
   localparam logic [1:0] ST_TMO   = 2'd3;
   localparam int         CW       = 32;

   state_t           r_state, w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_num, r_err, r_prev, r_stall, r_run;
   logic [1:0]       r_status, w_status;
   logic             r_tb_reset, r_tb_enable, r_tb_freeze, r_busy, r_done;
   logic             w_accept, w_timeout;

   assign w_timeout = (TIMEOUT != 0) && (r_stall == WIDTH'(TIMEOUT - 1));

   always_comb begin
      w_next   = r_state;
      w_status = r_status;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.i_start) begin
               w_next   = S_CLEAR;
               w_status = ST_PASS;
               w_accept = 1'b1;
            end
         end
         S_CLEAR: begin
            if (bus.i_abort) begin
               w_next   = S_DONE;
               w_status = ST_ABORT;
            end else if (r_cnt == CW'(RST_CYCLES - 1)) begin
               w_next = (r_num == '0) ? S_DONE : S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (bus.i_abort) begin
               w_next   = S_DONE;
               w_status = ST_ABORT;
            end else if (r_cnt == CW'(PIPE_LAT - 1)) begin
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            // exit checks in priority order; falling through all of them keeps running
            w_next = S_STOP;
            if (bus.i_abort) w_status = ST_ABORT;
            else if ((r_err != '0) && (bus.i_event_ctr >= r_err)) w_status = ST_FAIL;
            else if (bus.i_data_ctr >= r_num) w_status = (bus.i_event_ctr == '0) ? ST_PASS : ST_FAIL;
            else if (w_timeout) w_status = ST_TMO;
            else w_next = S_RUN;
         end
         S_STOP:  w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_num       <= '0;
         r_err       <= '0;
         r_prev      <= '0;
         r_stall     <= '0;
         r_run       <= '0;
         r_status    <= ST_PASS;
         r_tb_reset  <= 1'b1;
         r_tb_enable <= 1'b0;
         r_tb_freeze <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
         r_prev      <= bus.i_data_ctr;
         r_stall     <= (r_state != S_RUN || bus.i_data_ctr != r_prev) ? '0 :
                        (r_stall == '1) ? r_stall : r_stall + 1'b1;
         r_run       <= w_accept ? '0 : (r_state == S_RUN && r_run != '1) ? r_run + 1'b1 : r_run;
         r_status    <= w_status;
         r_num       <= w_accept ? bus.i_num_samples : r_num;
         r_err       <= w_accept ? bus.i_err_limit : r_err;
         // outputs decode the next state so they are registered in step with it
         r_tb_reset  <= (w_next == S_IDLE) || (w_next == S_CLEAR);
         r_tb_enable <= (w_next == S_FLUSH) || (w_next == S_RUN);
         r_tb_freeze <= (w_next != S_RUN);
         r_busy      <= (w_next != S_IDLE) && (w_next != S_DONE);
         r_done      <= (w_next == S_DONE);
      end
   end

   assign bus.o_tb_reset   = r_tb_reset;
   assign bus.o_tb_enable  = r_tb_enable;
   assign bus.o_tb_freeze  = r_tb_freeze;
   assign bus.o_busy       = r_busy;
   assign bus.o_done       = r_done;
   assign bus.o_status     = r_status;
   assign bus.o_run_cycles = r_run;
endmodule

// File: tb/tb_tb_run_controller.sv
// tb_tb_run_controller: directed and randomized runs checked cycle by cycle against a
// run-level model that derives the phase timeline, exit cycle and status from the run rules.
module tb_tb_run_controller;
   localparam int W    = 8;
   localparam int TMO  = 16;
   localparam int NMAX = 310;

   localparam logic [4:0] P_IDLE  = 5'b10100;
   localparam logic [4:0] P_CLEAR = 5'b10110;
   localparam logic [4:0] P_FLUSH = 5'b01110;
   localparam logic [4:0] P_RUN   = 5'b01010;
   localparam logic [4:0] P_STOP  = 5'b00110;
   localparam logic [4:0] P_DONE  = 5'b00101;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] w_outs;
   int         checks = 0;
   int         errors = 0;
   int         dq[0:319];
   int         eq[0:319];

   tb_run_controller_if #(.WIDTH(W)) bus ();

   tb_run_controller #(.WIDTH(W), .RST_CYCLES(4), .PIPE_LAT(8), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign w_outs = {bus.o_tb_reset, bus.o_tb_enable, bus.o_tb_freeze, bus.o_busy, bus.o_done};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Cycle k counts periods after the edge that accepts the start: CLEAR 1..4, FLUSH 5..12,
   // RUN cycle n is k=n+12. dq/eq hold the counters per RUN cycle, index 0 before RUN.
   task automatic run(input string name, input int num, input int errl, input int ab_at);
      int         done_k, stop_k, st, rc, stall, exit_n, st_at, idx;
      logic [4:0] exp;
      st = 0; rc = 0; stop_k = 0; exit_n = 0; stall = 0;
      if (ab_at >= 1 && ab_at <= (num == 0 ? 4 : 12)) begin
         done_k = ab_at + 1;
         st     = 2;
      end else if (num == 0) begin
         done_k = 5;
      end else begin
         for (int n = 1; n <= NMAX && exit_n == 0; n++) begin
            if (n + 12 == ab_at) begin st = 2; exit_n = n; end
            else if (errl != 0 && eq[n] >= errl) begin st = 1; exit_n = n; end
            else if (dq[n] >= num) begin st = (eq[n] == 0) ? 0 : 1; exit_n = n; end
            else if (stall == TMO - 1) begin st = 3; exit_n = n; end
            else stall = (dq[n] != dq[n-1]) ? 0 : (stall == 255 ? 255 : stall + 1);
         end
         rc     = (exit_n > 255) ? 255 : exit_n;
         stop_k = exit_n + 13;
         done_k = exit_n + 14;
      end
      st_at = (done_k >= 3) ? done_k - 2 : -1;
      bus.i_start       = 1'b1;
      bus.i_abort       = (ab_at == 0);
      bus.i_num_samples = W'(num);
      bus.i_err_limit   = W'(errl);
      bus.i_data_ctr    = W'(dq[0]);
      bus.i_event_ctr   = W'(eq[0]);
      for (int k = 1; k <= done_k; k++) begin
         @(negedge clk);
         exp = (k >= done_k) ? P_DONE : (k == stop_k) ? P_STOP :
               (k <= 4) ? P_CLEAR : (k <= 12) ? P_FLUSH : P_RUN;
         check($sformatf("%s ctl k=%0d", name, k), 32'(w_outs), 32'(exp));
         idx = (k <= 12) ? 0 : (k - 12 > 319 ? 319 : k - 12);
         bus.i_start     = (k == st_at);
         bus.i_abort     = (k == ab_at);
         bus.i_data_ctr  = W'(dq[idx]);
         bus.i_event_ctr = W'(eq[idx]);
      end
      check({name, " status"}, 32'(bus.o_status), 32'(st));
      check({name, " run_cycles"}, 32'(bus.o_run_cycles), 32'(rc));
   endtask

   initial begin
      int num, errl, ab_at, hold_from, sel;
      bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_num_samples = '0;
      bus.i_err_limit = '0; bus.i_data_ctr = '0; bus.i_event_ctr = '0;
      @(negedge clk);
      check("reset ctl", 32'(w_outs), 32'(P_IDLE));
      check("reset status", 32'(bus.o_status), 0);
      check("reset run_cycles", 32'(bus.o_run_cycles), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("idle hold", 32'(w_outs), 32'(P_IDLE));

      for (int n = 0; n < 320; n++) begin dq[n] = n; eq[n] = 0; end
      run("pass", 100, 0, -1);
      for (int n = 0; n < 320; n++) eq[n] = (n >= 97) ? 3 : 0;
      run("fail_end", 100, 0, -1);
      for (int n = 0; n < 320; n++) eq[n] = (n >= 40) ? 5 : n / 10;
      run("err_limit", 100, 5, -1);
      for (int n = 0; n < 320; n++) eq[n] = 0;
      run("abort_flush", 100, 0, 7);
      run("abort_run", 100, 0, 22);
      for (int n = 0; n < 320; n++) dq[n] = 7;
      run("timeout", 100, 0, -1);
      run("zero", 0, 0, -1);
      for (int n = 0; n < 320; n++) dq[n] = (n + 1) & 1;
      run("saturate", 200, 0, 312);

      for (int r = 0; r < 25; r++) begin
         num       = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 120));
         errl      = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
         hold_from = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : 1000;
         sel       = int'($urandom_range(0, 5));
         ab_at     = (sel == 1) ? 0 : (sel == 2) ? int'($urandom_range(1, 12)) :
                     (sel == 3) ? int'($urandom_range(13, 80)) : -1;
         dq[0] = int'($urandom_range(0, 10));
         eq[0] = 0;
         for (int n = 1; n < 320; n++) begin
            dq[n] = (n >= hold_from || $urandom_range(0, 3) == 0) ? dq[n-1] : dq[n-1] + int'($urandom_range(1, 2));
            if (dq[n] > 255) dq[n] = 255;
            eq[n] = eq[n-1] + ((sel >= 4 && $urandom_range(0, 29) == 0) ? 1 : 0);
         end
         run($sformatf("rnd%0d", r), num, errl, ab_at);
      end

      bus.i_start = 1'b1; bus.i_abort = 1'b0; bus.i_num_samples = W'(200);
      bus.i_err_limit = '0; bus.i_event_ctr = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         bus.i_start    = 1'b0;
         bus.i_data_ctr = W'(k & 1);
      end
      check("pre-reset ctl", 32'(w_outs), 32'(P_RUN));
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("async reset ctl", 32'(w_outs), 32'(P_IDLE));
      check("async reset status", 32'(bus.o_status), 0);
      check("async reset run_cycles", 32'(bus.o_run_cycles), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
